// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit with HI/LO registers.
// Signed operations work on magnitudes and apply sign correction in FIXUP.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_dbz_pend;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_accept;
  logic               w_mt_ok;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_a_neg  = op[0] & a[WIDTH-1];
  assign w_b_neg  = op[0] & b[WIDTH-1];
  assign w_accept = (r_state == S_IDLE) & start & ~flush;
  assign w_mt_ok  = (r_state == S_IDLE) & ~start;

  // Multiply: add the multiplicand into the upper half, then shift the whole product right.
  assign w_msum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_opb[0] ? {1'b0, r_opa} : '0);

  // Divide: the borrow bit of the trial subtraction is the inverted quotient bit.
  assign w_shift = {r_acc[WIDTH-1:0], r_opa[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_opb};
  assign w_qbit  = ~w_diff[WIDTH];

  // A zero divisor leaves |a| as remainder; restoring the dividend sign yields the original a.
  assign w_prod = r_neg_res ? f_neg2(r_acc) : r_acc;
  assign w_quo  = r_dbz_pend ? '1 : (r_neg_res ? f_neg(r_opa) : r_opa);
  assign w_rem  = r_neg_rem ? f_neg(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_CALC;
            r_cnt      <= CW'(WIDTH);
            r_busy     <= 1'b1;
            r_is_div   <= op[1];
            r_opa      <= w_a_neg ? f_neg(a) : a;
            r_opb      <= w_b_neg ? f_neg(b) : b;
            r_acc      <= '0;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_dbz_pend <= op[1] & (b == '0);
          end
          if (w_mt_ok && hi_we) r_hi <= wdata;
          if (w_mt_ok && lo_we) r_lo <= wdata;
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_is_div) begin
              r_acc <= {{(WIDTH-1){1'b0}}, (w_qbit ? w_diff : w_shift)};
              r_opa <= {r_opa[WIDTH-2:0], w_qbit};
            end else begin
              r_acc <= {w_msum, r_acc[WIDTH-1:1]};
              r_opb <= r_opb >> 1;
            end
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!flush) begin
            r_done <= 1'b1;
            r_dbz  <= r_dbz_pend;
            if (r_is_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the EX stage of the pipelined MIPS core. It implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers, plus the MTHI and MTLO writes. It is parametrised in operand width and runs one bit per cycle. While an operation is in flight it raises `busy`, which the hazard logic uses to stall any MFHI, MFLO or mul/div instruction that arrives behind it.

## Interface
Parameters:
- `WIDTH`, 32, operand width in bits; legal values are 4 and up.

Ports:
- `clk`, in, 1, single clock; everything is on the rising edge.
- `rst_n`, in, 1, reset, synchronous, active-low.
- `start`, in, 1, request a new operation; sampled only in IDLE.
- `op`, in, 2, operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`, in, WIDTH, multiplicand or dividend (rs).
- `b`, in, WIDTH, multiplier or divisor (rt).
- `flush`, in, 1, abort the in-flight operation (branch/jump squash).
- `hi_we`, in, 1, MTHI strobe.
- `lo_we`, in, 1, MTLO strobe.
- `wdata`, in, WIDTH, data for MTHI/MTLO.
- `busy`, out, 1, an operation is in flight.
- `done`, out, 1, one-cycle pulse; HI/LO hold the new result.
- `hi`, out, WIDTH, HI register: product upper half, or remainder.
- `lo`, out, WIDTH, LO register: product lower half, or quotient.
- `div_by_zero`, out, 1, set with `done` when a divide had b==0.

## Operation
- States: IDLE, CALC, FIXUP.
- Iteration counter width: $clog2(WIDTH+1).
- IDLE with `start`=1 and `flush`=0:
  - Latch `op`.
  - For signed ops, latch |a|, |b| and the result signs.
  - Clear the accumulator; counter = WIDTH; go to CALC.
- CALC: one iteration per cycle; counter decrements; on reaching 0, go to FIXUP.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, with a WIDTH+1-bit partial remainder.
- FIXUP:
  - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Write HI/LO; go to IDLE; pulse `done`.
- Signed multiply: full 2*WIDTH-bit two's-complement product.
- Signed divide truncates toward zero.
  - MIN/-1 gives lo=MIN and hi=0, with no trap and `div_by_zero`=0.
- Divide by zero (DIV or DIVU, b==0):
  - hi = original a; lo = all ones; `div_by_zero`=1.
  - Latency is the same as a normal divide.
- `div_by_zero` holds its value until the next `done`.
- `flush`:
  - In CALC or FIXUP: go to IDLE next edge. HI/LO are unchanged and there is no `done`.
  - In IDLE: any concurrent `start` is ignored.
- `start` while `busy` is ignored. The pipeline must not issue it; the bench checks that it is ignored.
- `hi_we`/`lo_we` are honoured only in IDLE with `start`=0. Both may be set in the same cycle. They are ignored otherwise.
- `rst_n`=0 at any edge, including mid-operation:
  - State goes to IDLE.
  - hi, lo, busy, done, div_by_zero all become 0.
  - The counter and accumulator are cleared.

## Timing
- Reset value of every output is 0.
- `start` is accepted at edge T.
- `busy`=1 in cycles T+1 through T+WIDTH+1, i.e. WIDTH+1 cycles (CALC plus FIXUP).
- HI/LO are written at edge T+WIDTH+1.
  - `done`=1 and `busy`=0 during cycle T+WIDTH+2, which is exactly one cycle.
  - This is 34 cycles after start for WIDTH=32.
- A new `start` may be accepted in the same cycle `done` is high.
- MTHI/MTLO take effect at the edge they are sampled; visible on `hi`/`lo` the next cycle.
- `busy` and `done` are registered, with no combinational path from inputs.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; `done` exactly 34 cycles after `start`; `busy` high for 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, `div_by_zero`=0.
- DIVU a=0x1234 b=0 -> hi=0x1234, lo=0xFFFFFFFF, `div_by_zero`=1. A following DIVU 100/7 -> lo=14, hi=2, `div_by_zero`=0.
- MTHI 0xAAAA then MULTU 3*4 with `flush` at cycle 10:
  - `busy` drops at cycle 11; no `done`; hi=0xAAAA and lo=0 remain.
  - `start` pulsed mid-operation in a separate run has no effect on the result or timing.
- `rst_n`=0 at cycle 20 of a DIV -> all outputs 0 the next cycle. A new MULTU 6*7 afterwards gives lo=42, hi=0 with normal latency.
